// File: rtl/pipes.sv
// Shared pipeline types: muldiv op encoding, decode control fields and sequencer states.
package pipes;

  localparam int MULDIV_XLEN      = 64;
  localparam int MULDIV_WORD_BITS = 32;

  typedef enum logic [2:0] {
    MULDIV_MUL  = 3'd0,
    MULDIV_DIV  = 3'd4,
    MULDIV_DIVU = 3'd5,
    MULDIV_REM  = 3'd6,
    MULDIV_REMU = 3'd7
  } muldiv_op_t;

  // op is kept as raw bits so reserved encodings can be carried and recognised.
  typedef struct packed {
    logic [2:0] op;
    logic       word;
  } muldiv_ctl_t;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_BUSY,
    MD_DONE
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_fixup.sv
// Combinational operand preparation (word extension, magnitudes, special cases)
// and result fixup (negation, word sign-extension) for the muldiv sequencer.
module muldiv_fixup
  import pipes::*;
#(
  parameter int XLEN = MULDIV_XLEN
) (
  input  logic [2:0]      op,
  input  logic            word,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] extA,
  output logic [XLEN-1:0] extB,
  output logic [XLEN-1:0] magA,
  output logic [XLEN-1:0] magB,
  output logic            qNeg,
  output logic            rNeg,
  output logic            divZero,
  output logic            overflow,
  output logic            reserved,
  input  logic [XLEN-1:0] rawRes,
  input  logic            negRes,
  input  logic            resWord,
  output logic [XLEN-1:0] fixRes
);

  logic            divSigned;
  logic            isDiv;
  logic            sgnExt;
  logic [XLEN-1:0] minVal;
  logic [XLEN-1:0] negated;

  always_comb begin
    divSigned = (op == MULDIV_DIV) || (op == MULDIV_REM);
    isDiv     = op[2];
    sgnExt    = divSigned || (op == MULDIV_MUL);
    reserved  = !isDiv && (op != MULDIV_MUL);

    extA = word ? {{(XLEN-32){sgnExt & a[31]}}, a[31:0]} : a;
    extB = word ? {{(XLEN-32){sgnExt & b[31]}}, b[31:0]} : b;

    qNeg = divSigned & (extA[XLEN-1] ^ extB[XLEN-1]);
    rNeg = divSigned & extA[XLEN-1];
    magA = (divSigned && extA[XLEN-1]) ? -extA : extA;
    magB = (divSigned && extB[XLEN-1]) ? -extB : extB;

    // Most negative dividend of the active width, already word-extended.
    minVal   = word ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
    divZero  = isDiv && (extB == '0);
    overflow = divSigned && (extA == minVal) && (extB == '1);

    negated = negRes ? -rawRes : rawRes;
    fixRes  = resWord ? {{(XLEN-32){negated[31]}}, negated[31:0]} : negated;
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative radix-2 multiply / restoring divide sequencer for the execute stage.
// One bit per cycle; special cases complete one cycle after accept.
module muldiv_ctrl
  import pipes::*;
#(
  parameter int XLEN = MULDIV_XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      op,
  input  logic            word,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data
);

  localparam int CW = $clog2(XLEN + 1);

  muldiv_state_t   state;
  muldiv_ctl_t     ctl;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] acc, x, y, quo;
  logic            qNegR, rNegR;

  logic [XLEN-1:0] extA, extB, magA, magB, fixRes, rawRes;
  logic            qNeg, rNeg, divZero, overflow, reserved, negRes, resWord, special;
  logic [XLEN-1:0] accNext, xNext, yNext, quoNext, specRaw, iterRaw;
  logic [XLEN:0]   remShift, remSub;
  logic            iterNeg;

  muldiv_fixup #(.XLEN(XLEN)) uFixup (
    .op(op), .word(word), .a(a), .b(b),
    .extA(extA), .extB(extB), .magA(magA), .magB(magB),
    .qNeg(qNeg), .rNeg(rNeg), .divZero(divZero), .overflow(overflow), .reserved(reserved),
    .rawRes(rawRes), .negRes(negRes), .resWord(resWord), .fixRes(fixRes)
  );

  assign req_ready = (state == MD_IDLE);
  assign special   = reserved || divZero || overflow;

  // One iteration: acc is the product accumulator for MUL and the partial remainder for div.
  always_comb begin
    accNext  = acc;
    xNext    = x;
    yNext    = y;
    quoNext  = quo;
    remShift = '0;
    remSub   = '0;
    if (ctl.op == MULDIV_MUL) begin
      if (y[0]) accNext = acc + x;
      xNext = x << 1;
      yNext = y >> 1;
    end else begin
      remShift = {acc, x[XLEN-1]};
      remSub   = remShift - {1'b0, y};
      xNext    = x << 1;
      if (remShift >= {1'b0, y}) begin
        accNext = remSub[XLEN-1:0];
        quoNext = {quo[XLEN-2:0], 1'b1};
      end else begin
        accNext = remShift[XLEN-1:0];
        quoNext = {quo[XLEN-2:0], 1'b0};
      end
    end
  end

  // The fixup unit serves the accept path while idle and the final iteration otherwise.
  always_comb begin
    specRaw = '0;
    if (reserved)      specRaw = '0;
    else if (divZero)  specRaw = op[1] ? extA : '1;
    else if (overflow) specRaw = op[1] ? '0 : extA;
    iterRaw = (ctl.op == MULDIV_MUL || ctl.op[1]) ? accNext : quoNext;
    iterNeg = (ctl.op == MULDIV_MUL) ? 1'b0 : (ctl.op[1] ? rNegR : qNegR);
    rawRes  = (state == MD_IDLE) ? specRaw : iterRaw;
    negRes  = (state == MD_IDLE) ? 1'b0    : iterNeg;
    resWord = (state == MD_IDLE) ? word    : ctl.word;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= MD_IDLE;
      ctl        <= '0;
      cnt        <= '0;
      acc        <= '0;
      x          <= '0;
      y          <= '0;
      quo        <= '0;
      qNegR      <= 1'b0;
      rNegR      <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
    end else if (flush) begin
      state      <= MD_IDLE;
      cnt        <= '0;
      resp_valid <= 1'b0;
    end else begin
      case (state)
        MD_IDLE: if (req_valid) begin
          ctl   <= '{op: op, word: word};
          qNegR <= qNeg;
          rNegR <= rNeg;
          if (special) begin
            state      <= MD_DONE;
            resp_valid <= 1'b1;
            resp_data  <= fixRes;
          end else begin
            state <= MD_BUSY;
            cnt   <= word ? CW'(MULDIV_WORD_BITS) : CW'(XLEN);
            acc   <= '0;
            quo   <= '0;
            if (op == MULDIV_MUL) begin
              x <= extA;
              y <= extB;
            end else begin
              // Word dividends are pre-aligned so the next bit is always the MSB.
              x <= word ? (magA << MULDIV_WORD_BITS) : magA;
              y <= magB;
            end
          end
        end
        MD_BUSY: begin
          acc <= accNext;
          x   <= xNext;
          y   <= yNext;
          quo <= quoNext;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state      <= MD_DONE;
            resp_valid <= 1'b1;
            resp_data  <= fixRes;
          end
        end
        MD_DONE: if (resp_ready) begin
          state      <= MD_IDLE;
          resp_valid <= 1'b0;
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: scoreboarded results, latency, back-pressure, flush, async reset.
module tb_muldiv_ctrl;
  import pipes::*;

  logic        clk = 1'b0;
  logic        reset, flush, req_valid, req_ready, word, resp_valid, resp_ready;
  logic [2:0]  op;
  logic [63:0] a, b, resp_data;

  int nAssert = 0;
  int nFail   = 0;

  typedef struct {
    logic [63:0] data;
    int          lat;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  muldiv_ctrl #(.XLEN(64)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .op(op), .word(word), .a(a), .b(b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    nAssert++;
    assert (obs === expv) else begin
      nFail++;
      $error("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic issue(input string tag, input logic [2:0] o, input logic w,
                       input logic [63:0] av, input logic [63:0] bv,
                       input logic [63:0] expD, input int expLat, input int hold);
    exp_t        e;
    int          cyc;
    logic        busyOk, stable;
    logic [63:0] held;
    @(negedge clk);
    check({tag, " ready"}, {63'b0, req_ready}, 64'd1);
    op = o; word = w; a = av; b = bv; req_valid = 1'b1;
    e.data = expD; e.lat = expLat;
    sb.push_back(e);
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    cyc = 1; busyOk = 1'b1;
    while (!resp_valid && cyc < 200) begin
      if (req_ready) busyOk = 1'b0;
      @(negedge clk);
      cyc++;
    end
    if (req_ready) busyOk = 1'b0;
    e = sb.pop_front();
    check({tag, " valid"}, {63'b0, resp_valid}, 64'd1);
    check({tag, " latency"}, 64'(cyc), 64'(e.lat));
    check({tag, " not-ready"}, {63'b0, busyOk}, 64'd1);
    check({tag, " data"}, resp_data, e.data);
    if (hold > 0) begin
      held = resp_data; stable = 1'b1;
      repeat (hold) begin
        @(negedge clk);
        if (!resp_valid || resp_data !== held) stable = 1'b0;
      end
      check({tag, " hold"}, {63'b0, stable}, 64'd1);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1 resp_ready = 1'b0;
    @(negedge clk);
    check({tag, " idle"}, {62'b0, req_ready, resp_valid}, 64'd2);
  endtask

  initial begin
    int   k;
    logic saw;
    exp_t dummy;
    reset = 1'b1; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    op = '0; word = 1'b0; a = '0; b = '0;
    #1;
    check("reset state", {req_ready, resp_valid, resp_data[61:0]}, 64'h8000_0000_0000_0000);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    issue("MUL",    3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65, 0);
    issue("DIV",    3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, 5);
    issue("REM",    3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0);
    issue("DIV2",   3'd4, 1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, 65, 0);
    issue("REM2",   3'd6, 1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 65, 0);
    issue("DIVU0",  3'd5, 1'b0, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
    issue("REMU0",  3'd7, 1'b0, 64'd100, 64'd0, 64'd100, 1, 0);
    issue("DIV0",   3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
    issue("DIVWovf",3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1, 3);
    issue("REMWovf",3'd6, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, 0);
    issue("DIVUW",  3'd5, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 33, 0);
    issue("DIVW",   3'd4, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'hABCD_0000_0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, 33, 0);
    issue("REMUW",  3'd7, 1'b1, 64'h0000_0000_8000_0005, 64'h10, 64'd5, 33, 0);
    issue("MULW",   3'd0, 1'b1, 64'h0000_0000_4000_0000, 64'd2, 64'hFFFF_FFFF_8000_0000, 33, 0);
    issue("RSVD",   3'd3, 1'b0, 64'd55, 64'd66, 64'd0, 1, 0);

    // Flush at BUSY cycle 10: unit idles next cycle and never responds.
    @(negedge clk);
    op = 3'd0; word = 1'b0; a = 64'd9; b = 64'd9; req_valid = 1'b1;
    dummy.data = 64'd81; dummy.lat = 65;
    sb.push_back(dummy);
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    void'(sb.pop_back());
    @(negedge clk);
    check("flush idle", {62'b0, req_ready, resp_valid}, 64'd2);
    saw = 1'b0;
    for (k = 0; k < 70; k++) begin
      @(negedge clk);
      if (resp_valid) saw = 1'b1;
    end
    check("flush no resp", {63'b0, saw}, 64'd0);

    issue("postflush", 3'd7, 1'b0, 64'd23, 64'd5, 64'd3, 65, 0);

    // Asynchronous reset in the middle of BUSY.
    @(negedge clk);
    op = 3'd4; word = 1'b0; a = 64'd1000; b = 64'd7; req_valid = 1'b1;
    dummy.data = 64'd142; dummy.lat = 65;
    sb.push_back(dummy);
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async reset", {req_ready, resp_valid, resp_data[61:0]}, 64'h8000_0000_0000_0000);
    void'(sb.pop_back());
    @(negedge clk);
    reset = 1'b0;
    saw = 1'b0;
    for (k = 0; k < 70; k++) begin
      @(negedge clk);
      if (resp_valid) saw = 1'b1;
    end
    check("reset no resp", {63'b0, saw}, 64'd0);
    check("scoreboard empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
